// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - 2-way, 8-set read cache controller with 8-beat block refill
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cpu_valid, cpu_addr   read request in; accepted only while cpu_ready
//   cpu_ready             high only while idle
//   cpu_done, cpu_hit     one-cycle completion pulse, hit qualifier
//   mem_req, mem_addr     one-cycle refill request, block-aligned refill address
//   mem_rvalid, mem_rdata refill beats (8 x 32 bits)
//   index, write, WF      way array set index, one-hot write strobe, one-hot output select
//   inblock               assembled refill block
module cache_controller #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic              cpu_hit,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [2:0]        index,
  output logic [1:0]        write,
  output logic [1:0]        WF,
  output logic [255:0]      inblock
);
  localparam int TAG_W = ADDR_W - 8;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, FILL, RESPOND} state_t;

  state_t                        state_q, state_d;
  logic [TAG_W-1:0]              req_tag_q, req_tag_d;
  logic [2:0]                    set_q, set_d;
  logic [1:0][7:0][TAG_W-1:0]    tag_q, tag_d;
  logic [1:0][7:0]               valid_q, valid_d;
  logic [7:0]                    lru_q, lru_d;       // per set: the least recently used way
  logic [2:0]                    beat_q, beat_d;
  logic                          victim_q, victim_d;
  logic                          cpu_ready_q, cpu_ready_d;
  logic                          cpu_done_q, cpu_done_d;
  logic                          cpu_hit_q, cpu_hit_d;
  logic                          mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]             mem_addr_q, mem_addr_d;
  logic [1:0]                    write_q, write_d;
  logic [1:0]                    wf_q, wf_d;
  logic [255:0]                  inblock_q, inblock_d;

  logic hit0, hit1;
  logic unused_offset;

  // Byte offset never matters: only whole blocks are handled here.
  assign unused_offset = ^cpu_addr[4:0];

  assign hit0 = valid_q[0][set_q] && (tag_q[0][set_q] == req_tag_q);
  assign hit1 = valid_q[1][set_q] && (tag_q[1][set_q] == req_tag_q);

  function automatic logic [1:0] onehot(input logic w);
    return w ? 2'b10 : 2'b01;
  endfunction

  always_comb begin
    state_d    = state_q;
    req_tag_d  = req_tag_q;
    set_d      = set_q;
    tag_d      = tag_q;
    valid_d    = valid_q;
    lru_d      = lru_q;
    beat_d     = beat_q;
    victim_d   = victim_q;
    mem_addr_d = mem_addr_q;
    inblock_d  = inblock_q;
    cpu_done_d = 1'b0;
    cpu_hit_d  = 1'b0;
    mem_req_d  = 1'b0;
    write_d    = 2'b00;
    wf_d       = 2'b00;

    case (state_q)
      IDLE: begin
        if (cpu_valid && cpu_ready_q) begin
          req_tag_d = cpu_addr[ADDR_W-1:8];
          set_d     = cpu_addr[7:5];
          state_d   = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit0 || hit1) begin
          // Way 0 wins if both match; installs only happen on a miss so this cannot occur.
          cpu_done_d   = 1'b1;
          cpu_hit_d    = 1'b1;
          wf_d         = onehot(!hit0);
          lru_d[set_q] = hit0;
          state_d      = IDLE;
        end else begin
          if (!valid_q[0][set_q])      victim_d = 1'b0;
          else if (!valid_q[1][set_q]) victim_d = 1'b1;
          else                         victim_d = lru_q[set_q];
          mem_req_d  = 1'b1;
          mem_addr_d = {req_tag_q, set_q, 5'b0};
          beat_d     = 3'd0;
          state_d    = REFILL;
        end
      end
      REFILL: begin
        if (mem_rvalid) begin
          inblock_d[{beat_q, 5'b0} +: 32] = mem_rdata;
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) begin
            write_d = onehot(victim_q);   // registered, so the strobe lands in the FILL cycle
            state_d = FILL;
          end
        end
      end
      FILL: begin
        tag_d[victim_q][set_q]   = req_tag_q;
        valid_d[victim_q][set_q] = 1'b1;
        lru_d[set_q]             = !victim_q;
        cpu_done_d               = 1'b1;
        wf_d                     = onehot(victim_q);
        state_d                  = RESPOND;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cpu_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_tag_q   <= '0;
      set_q       <= '0;
      tag_q       <= '0;
      valid_q     <= '0;
      lru_q       <= '0;
      beat_q      <= '0;
      victim_q    <= 1'b0;
      cpu_ready_q <= 1'b1;
      cpu_done_q  <= 1'b0;
      cpu_hit_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      write_q     <= '0;
      wf_q        <= '0;
      inblock_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_tag_q   <= req_tag_d;
      set_q       <= set_d;
      tag_q       <= tag_d;
      valid_q     <= valid_d;
      lru_q       <= lru_d;
      beat_q      <= beat_d;
      victim_q    <= victim_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_done_q  <= cpu_done_d;
      cpu_hit_q   <= cpu_hit_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      write_q     <= write_d;
      wf_q        <= wf_d;
      inblock_q   <= inblock_d;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_done  = cpu_done_q;
  assign cpu_hit   = cpu_hit_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign index     = set_q;
  assign write     = write_q;
  assign WF        = wf_q;
  assign inblock   = inblock_q;
endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32: byte-address width; tag width = ADDR_W-8 (5 offset bits, 3 index bits).
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 The block SHALL have port cpu_valid, input, 1: read request present.
REQ-005 The block SHALL have port cpu_addr, input, ADDR_W: request byte address, sampled only when cpu_valid && cpu_ready.
REQ-006 The block SHALL have port cpu_ready, output, 1: high only in IDLE.
REQ-007 The block SHALL have port cpu_done, output, 1: one-cycle pulse when the requested block is selected on the way array output.
REQ-008 The block SHALL have port cpu_hit, output, 1: qualifies cpu_done; 1 = hit, 0 = miss serviced by refill.
REQ-009 The block SHALL have port mem_req, output, 1: one-cycle refill request pulse.
REQ-010 The block SHALL have port mem_addr, output, ADDR_W: block-aligned refill address {tag,index,5'b0}, held stable throughout REFILL.
REQ-011 The block SHALL have port mem_rvalid, input, 1: refill beat valid.
REQ-012 The block SHALL have port mem_rdata, input, 32: refill beat data.
REQ-013 The block SHALL have port index, output, 3: set index to the way array (latched addr[7:5]).
REQ-014 The block SHALL have port write, output, 2: one-hot way write strobe to the way array.
REQ-015 The block SHALL have port WF, output, 2: one-hot way select for the way array output tristates; never 2'b11.
REQ-016 The block SHALL have port inblock, output, 256: assembled refill block.

Function
REQ-017 The block SHALL hold per-set, per-way tag and valid bits (2 ways x 8 sets) and one LRU bit per set naming the least recently used way.
REQ-018 The block SHALL implement states IDLE, LOOKUP, REFILL, FILL, RESPOND.
REQ-019 In IDLE, cpu_valid SHALL latch cpu_addr and transition to LOOKUP next cycle; cpu_valid outside IDLE SHALL be ignored.
REQ-020 In LOOKUP, hit in way w (valid && tag match) SHALL assert cpu_done=1, cpu_hit=1, WF=onehot(w), set LRU[index]=~w, and return to IDLE (hit latency: done 1 cycle after accept).
REQ-021 In LOOKUP, on miss, victim SHALL be way 0 if invalid, else way 1 if invalid, else LRU[index]; mem_req SHALL pulse and state SHALL go to REFILL.
REQ-022 In REFILL, each mem_rvalid beat k (3-bit counter, 0..7) SHALL write mem_rdata into inblock[32k+31:32k]; after beat 7 state SHALL go to FILL; counter wraps to 0.
REQ-023 mem_rvalid outside REFILL SHALL be ignored; gaps between beats SHALL be tolerated without timeout.
REQ-024 In FILL (one cycle), write=onehot(victim) with WF=0, and tag/valid for victim SHALL update, LRU[index]=~victim.
REQ-025 In RESPOND (one cycle), cpu_done=1, cpu_hit=0, WF=onehot(victim), then IDLE.
REQ-026 write and WF SHALL be 0 in every state/cycle not listed above; write and WF SHALL never be asserted in the same cycle.
REQ-027 inblock SHALL hold its value outside REFILL.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, clear all valid and LRU bits, beat counter 0, and outputs cpu_ready=1, cpu_done=0, cpu_hit=0, mem_req=0, write=0, WF=0, index=0, mem_addr=0, inblock=0.
REQ-029 Reset asserted mid-REFILL SHALL abort the refill; partial beats SHALL not install a line.

Verification
REQ-030 Cold miss: after reset, read 0x0000_0040 -> mem_req with mem_addr 0x0000_0040, 8 beats 0x11..0x88 -> write=2'b01, index=2, then cpu_done, cpu_hit=0, WF=2'b01, inblock[31:0]=0x11.
REQ-031 Hit: re-read 0x0000_0044 -> cpu_done exactly 1 cycle after accept, cpu_hit=1, WF=2'b01, no mem_req.
REQ-032 Second way and LRU: read 0x0000_1040 (same set 2) -> fills way 1; read 0x0000_0040 hits way 0; read 0x0000_2040 -> evicts way 1 (write=2'b10).
REQ-033 Stalled beats: gaps of 0..5 idle cycles between mem_rvalid beats and spurious mem_rvalid in IDLE -> identical inblock, no extra writes.
REQ-034 Reset after beat 4 of a refill -> IDLE, cpu_ready=1; re-read same address misses (valid cleared).
REQ-035 Assertions throughout: WF never 2'b11, write onehot-or-zero, write&&WF never both nonzero, cpu_ready only in IDLE.
